// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the 4-channel merger and its matching
// demultiplexer, so both ends agree on the SEL tag encoding.
//   NUM_CH   : number of channels
//   ch_sel_t : 2-bit channel tag
//   CH_W..Z  : tag values for each channel
package demux_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef logic [1:0] ch_sel_t;

    localparam ch_sel_t CH_W = 2'd0;
    localparam ch_sel_t CH_X = 2'd1;
    localparam ch_sel_t CH_Y = 2'd2;
    localparam ch_sel_t CH_Z = 2'd3;

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin arbiter.
//   req     : per-channel request
//   last    : most recently granted channel
//   en      : grant allowed this cycle
//   gnt     : one-hot grant (all zero when en=0 or no request)
//   gnt_idx : index of the granted channel (0 when nothing is granted)
module rr_arbiter4
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_sel_t           last,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output ch_sel_t           gnt_idx
);

    ch_sel_t w_idx;

    // Walk offsets from farthest to nearest so the closest requester after
    // `last` is the final one written. Offset NUM_CH wraps back to `last`.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_idx   = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            w_idx = ch_sel_t'(last + ch_sel_t'(i));
            if (en && req[w_idx]) begin
                gnt        = '0;
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/demux_merge4.sv
// demux_merge4: merges channels W/X/Y/Z onto one registered output stream A
// using round-robin arbitration and valid/ready handshakes.
//   clk, rst_n             : clock, async active-low reset
//   {w,x,y,z}_data/_valid  : channel inputs
//   {w,x,y,z}_ready        : channel accepted this cycle (combinational)
//   a_data, a_sel, a_valid : registered output word, source tag, occupancy
//   a_ready                : downstream accepts the output word
module demux_merge4
    import demux_pkg::*;
#(
    parameter int unsigned DW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] w_data,
    input  logic [DW-1:0] x_data,
    input  logic [DW-1:0] y_data,
    input  logic [DW-1:0] z_data,
    input  logic          w_valid,
    input  logic          x_valid,
    input  logic          y_valid,
    input  logic          z_valid,
    output logic          w_ready,
    output logic          x_ready,
    output logic          y_ready,
    output logic          z_ready,
    output logic [DW-1:0] a_data,
    output logic [1:0]    a_sel,
    output logic          a_valid,
    input  logic          a_ready
);

    logic [DW-1:0]     r_a_data;
    ch_sel_t           r_a_sel;
    logic              r_a_valid;
    ch_sel_t           r_last;

    logic              w_load_en;
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_gnt;
    ch_sel_t           w_gnt_idx;
    logic [DW-1:0]     w_load_data;

    // rst_n gates the grant so no channel sees ready while held in reset.
    assign w_load_en = (!r_a_valid || a_ready) && rst_n;
    assign w_req     = {z_valid, y_valid, x_valid, w_valid};

    rr_arbiter4 u_arb (
        .req     (w_req),
        .last    (r_last),
        .en      (w_load_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_ready = w_gnt[CH_W];
    assign x_ready = w_gnt[CH_X];
    assign y_ready = w_gnt[CH_Y];
    assign z_ready = w_gnt[CH_Z];

    always_comb begin
        w_load_data = '0;
        unique case (w_gnt_idx)
            CH_W: w_load_data = w_data;
            CH_X: w_load_data = x_data;
            CH_Y: w_load_data = y_data;
            CH_Z: w_load_data = z_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_data  <= '0;
            r_a_sel   <= CH_W;
            r_a_valid <= 1'b0;
            r_last    <= CH_Z;
        end else if (|w_gnt) begin
            r_a_data  <= w_load_data;
            r_a_sel   <= w_gnt_idx;
            r_a_valid <= 1'b1;
            r_last    <= w_gnt_idx;
        end else if (a_ready) begin
            r_a_valid <= 1'b0;
        end
    end

    assign a_data  = r_a_data;
    assign a_sel   = r_a_sel;
    assign a_valid = r_a_valid;

endmodule

// File: tb/tb_demux_merge4.sv
// tb_demux_merge4: directed bench for demux_merge4 with a behavioural
// reference model checked on every falling edge plus literal expectations.
module tb_demux_merge4;
    import demux_pkg::*;

    localparam int unsigned DW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] w_data = '0, x_data = '0, y_data = '0, z_data = '0;
    logic          w_valid = 1'b0, x_valid = 1'b0, y_valid = 1'b0, z_valid = 1'b0;
    logic          w_ready, x_ready, y_ready, z_ready;
    logic [DW-1:0] a_data;
    logic [1:0]    a_sel;
    logic          a_valid;
    logic          a_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_merge4 #(.DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_data  (w_data),
        .x_data  (x_data),
        .y_data  (y_data),
        .z_data  (z_data),
        .w_valid (w_valid),
        .x_valid (x_valid),
        .y_valid (y_valid),
        .z_valid (z_valid),
        .w_ready (w_ready),
        .x_ready (x_ready),
        .y_ready (y_ready),
        .z_ready (z_ready),
        .a_data  (a_data),
        .a_sel   (a_sel),
        .a_valid (a_valid),
        .a_ready (a_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int        m_last  = 3;
    bit        m_valid = 1'b0;
    int        m_data  = 0;
    int        m_sel   = 0;

    function automatic bit ch_valid(input int c);
        case (c)
            0: return w_valid;
            1: return x_valid;
            2: return y_valid;
            default: return z_valid;
        endcase
    endfunction

    function automatic int ch_data(input int c);
        case (c)
            0: return int'(w_data);
            1: return int'(x_data);
            2: return int'(y_data);
            default: return int'(z_data);
        endcase
    endfunction

    // Channel that would transfer this cycle, or -1.
    function automatic int m_grant();
        if (!rst_n) return -1;
        if (m_valid && !a_ready) return -1;
        for (int k = 1; k <= 4; k++) begin
            if (ch_valid((m_last + k) % 4)) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last  = 3;
            m_valid = 1'b0;
            m_data  = 0;
            m_sel   = 0;
        end else begin
            int g;
            g = m_grant();
            if (g >= 0) begin
                m_data  = ch_data(g);
                m_sel   = g;
                m_valid = 1'b1;
                m_last  = g;
            end else if (a_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        g = m_grant();
        chk("w_ready", int'(w_ready), int'(g == 0));
        chk("x_ready", int'(x_ready), int'(g == 1));
        chk("y_ready", int'(y_ready), int'(g == 2));
        chk("z_ready", int'(z_ready), int'(g == 3));
        chk("a_valid", int'(a_valid), int'(m_valid));
        chk("a_data",  int'(a_data),  m_data);
        chk("a_sel",   int'(a_sel),   m_sel);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_valid(input bit v);
        w_valid = v; x_valid = v; y_valid = v; z_valid = v;
    endtask

    task automatic chk_out(input string name, input int v, input int s, input int d);
        chk({name, "_valid"}, int'(a_valid), v);
        chk({name, "_sel"},   int'(a_sel),   s);
        chk({name, "_data"},  int'(a_data),  d);
    endtask

    task automatic chk_rdy(input string name, input int r);
        chk(name, int'({z_ready, y_ready, x_ready, w_ready}), r);
    endtask

    int exp_sel[5]  = '{0, 1, 2, 3, 0};
    int exp_data[5] = '{1, 2, 3, 0, 1};

    initial begin
        // Reset, idle: every channel requesting while in reset.
        w_data = 2'b01; x_data = 2'b10; y_data = 2'b11; z_data = 2'b00;
        all_valid(1'b1);
        a_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_rdy("rst_ready", 0);
        chk_out("rst", 0, 0, 0);
        rst_n = 1'b1;

        // Round-robin across all four channels, W first after reset.
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("rr", 1, exp_sel[i], exp_data[i]);
        end

        // X loads, then stall for three cycles.
        step();
        chk_out("bp_load", 1, 1, 2);
        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_rdy("bp_ready", 0);
            step();
            chk_out("bp_hold", 1, 1, 2);
        end
        a_ready = 1'b1;
        #1;
        chk_rdy("bp_release_ready", 4'b0100);
        step();
        chk_out("bp_noblubble", 1, 2, 3);

        // Z next, leaving last=Z; then only Y requests.
        step();
        chk_out("z_load", 1, 3, 0);
        all_valid(1'b0);
        y_valid = 1'b1;
        y_data  = 2'b10;
        #1;
        chk_rdy("sparse_ready", 4'b0100);
        step();
        chk_out("sparse", 1, 2, 2);
        y_valid = 1'b0;
        step();
        chk("sparse_drain", int'(a_valid), 0);

        // Priority skip: last=X, then W and Z request.
        x_valid = 1'b1;
        x_data  = 2'b01;
        step();
        chk_out("skip_x", 1, 1, 1);
        x_valid = 1'b0;
        w_valid = 1'b1; w_data = 2'b11;
        z_valid = 1'b1; z_data = 2'b10;
        step();
        chk_out("skip_z", 1, 3, 2);
        z_valid = 1'b0;
        step();
        chk_out("skip_w", 1, 0, 3);

        // Reset while full and stalled.
        a_ready = 1'b0;
        x_valid = 1'b1;
        step();
        chk_out("stall", 1, 0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(a_valid), 0);
        chk_rdy("async_rst_ready", 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        all_valid(1'b1);
        a_ready = 1'b1;
        w_data = 2'b01;
        step();
        chk_out("post_rst", 1, 0, 1);

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
